gate_bist: RTL and testbench

Built-in self-test controller for a single 2-input combinational gate. It sweeps the gate inputs through all four `{A,B}` combinations, waits a programmable settle time, and samples the gate output `F`. Each sample is compared against a parameterised truth table, and the block reports per-vector failures, an error count and a pass flag. It sits beside the gate under test in the same clock domain and replaces the simulation-only stimulus/check flow with synthesizable hardware that also runs on silicon/FPGA.

---
 rtl/gate_bist.sv | 104 ++++++++++
 tb/tb_gate_bist.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// BIST controller for one 2-input gate: sweeps {A,B}=0..3, settles, samples F against TRUTH.
// Optional GATE_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_bist #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [2:0] r_err;
  logic [3:0] r_fv;
  logic       r_pass;
  logic       w_sample;
  logic       w_mis;
  logic [2:0] w_err_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_mis       = (F != TRUTH[r_idx]);
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (r_cnt == 8'd0) begin
          w_sample = 1'b1;
          if (r_idx == 2'd3) w_state_nxt = S_DONE;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          if (w_mis) w_state_nxt = S_DONE;
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_err_nxt = r_err + {2'b00, (w_sample && w_mis)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 8'd0;
      r_err   <= 3'd0;
      r_fv    <= 4'd0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx  <= 2'd0;
            r_cnt  <= RELOAD;
            r_err  <= 3'd0;
            r_fv   <= 4'd0;
            r_pass <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (!w_sample) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_err <= w_err_nxt;
            if (w_mis) r_fv[r_idx] <= 1'b1;
            // pass is resolved on the final sampling edge so it is valid alongside done
            if (w_state_nxt == S_DONE) begin
              r_pass <= (w_err_nxt == 3'd0);
            end else begin
              r_idx <= r_idx + 2'd1;
              r_cnt <= RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_DRIVE);
  assign done     = (r_state == S_DONE);
  assign A        = busy & r_idx[1];
  assign B        = busy & r_idx[0];
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_vec = r_fv;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist with a scoreboard of expected sweep results.
module tb_gate_bist;

  localparam logic [3:0] TRUTH  = 4'b1000;
  localparam int         SETTLE = 10;

  localparam logic [1:0] M_AND = 2'd0, M_ST0 = 2'd1, M_ST1 = 2'd2, M_OR = 2'd3;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fv;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       A, B, F, busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [1:0] mode = M_AND;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  gate_bist #(.TRUTH(TRUTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .F(F),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      M_AND:   F = A & B;
      M_ST0:   F = 1'b0;
      M_ST1:   F = 1'b1;
      default: F = A | B;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m);
    exp_t       e;
    logic [1:0] v;
    logic       f;
    bit         stop;
    e.err = 3'd0; e.fv = 4'd0; e.cyc = 4 * SETTLE + 1; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      case (m)
        M_AND:   f = v[1] & v[0];
        M_ST0:   f = 1'b0;
        M_ST1:   f = 1'b1;
        default: f = v[1] | v[0];
      endcase
      if (!stop && f != TRUTH[i]) begin
        e.fv[i] = 1'b1;
        e.err   = e.err + 3'd1;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        e.cyc = (i + 1) * SETTLE + 1;
        stop  = 1'b1;
`endif
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  // Called just after the accepting edge; n counts edges from edge 0 inclusive.
  task automatic track(input string tag);
    exp_t e;
    int   n;
    bit   seen;
    n = 1; seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_vec"}, {6'd0, A, B}, 8'((n - 1) / SETTLE));
      @(posedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, {7'd0, seen}, 8'd1);
    chk({tag, "_done_cyc"}, 8'(n), 8'(e.cyc));
    chk({tag, "_err_cnt"}, {5'd0, err_cnt}, {5'd0, e.err});
    chk({tag, "_fail_vec"}, {4'd0, fail_vec}, {4'd0, e.fv});
    chk({tag, "_pass"}, {7'd0, pass}, {7'd0, e.pass});
    chk({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic run_sweep(input string tag, input logic [1:0] m);
    mode = m;
    sb.push_back(model(m));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    track(tag);
  endtask

  initial begin
    int dones;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_A", {7'd0, A}, 8'd0);
    chk("rst_B", {7'd0, B}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_pass", {7'd0, pass}, 8'd0);
    chk("rst_err", {5'd0, err_cnt}, 8'd0);
    chk("rst_fv", {4'd0, fail_vec}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep("and_good", M_AND);
    repeat (3) @(negedge clk);
    chk("and_pass_hold", {7'd0, pass}, 8'd1);
    run_sweep("stuck0", M_ST0);
    run_sweep("stuck1", M_ST1);
    run_sweep("or_gate", M_OR);

    // start held high throughout: no restart until the IDLE cycle after done
    mode = M_ST1;
    sb.push_back(model(M_ST1));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
      chk("hold_busy", {7'd0, busy}, 8'd1);
    end
    void'(sb.pop_front());
    chk("hold_done", {7'd0, done}, 8'd1);
    @(negedge clk);
    chk("hold_idle_busy", {7'd0, busy}, 8'd0);
    chk("hold_idle_pass", {7'd0, pass}, 8'd0);
    mode = M_AND;
    sb.push_back(model(M_AND));
    @(posedge clk);
    #1;
    chk("hold_restart_busy", {7'd0, busy}, 8'd1);
    chk("hold_clr_err", {5'd0, err_cnt}, 8'd0);
    chk("hold_clr_fv", {4'd0, fail_vec}, 8'd0);
    chk("hold_clr_pass", {7'd0, pass}, 8'd0);
    start = 1'b0;
    track("hold_second");

    // asynchronous abort mid-sweep
    mode = M_ST1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_A", {7'd0, A}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_err", {5'd0, err_cnt}, 8'd0);
    chk("abort_fv", {4'd0, fail_vec}, 8'd0);
    chk("abort_pass", {7'd0, pass}, 8'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 8'(dones), 8'd0);
    run_sweep("after_abort", M_AND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
